// File: rtl/alarm_ring_scheduler.sv
// Alarm buzzer scheduler: queues BCD alarm matches on the 1 Hz tick and serves them
// one at a time with stop, snooze and auto-timeout. Optional macro: ALARM_SNOOZE_LIMIT_EN.
module alarm_ring_scheduler #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_1hz,
    input  logic [23:0] cur_time,
    input  logic [23:0] alarm_time1,
    input  logic [23:0] alarm_time2,
    input  logic [23:0] alarm_time3,
    input  logic [2:0]  alarm_en,
    input  logic        stop_btn,
    input  logic        snooze_btn,
    output logic        ring,
    output logic [1:0]  ring_id,
    output logic [2:0]  pending,
    output logic        snoozing
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    localparam logic [7:0] RING_LIMIT = 8'(RING_SECONDS);
    localparam logic [9:0] SNZ_LIMIT  = 10'(SNOOZE_SECONDS);

    state_e      state_q, state_d;
    logic        ring_q, ring_d;
    logic [1:0]  ring_id_q, ring_id_d;
    logic [2:0]  pending_q, pending_d;
    logic        snoozing_q, snoozing_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [9:0]  snz_cnt_q, snz_cnt_d;
    logic        stop_btn_q, stop_btn_d;
    logic        snz_btn_q, snz_btn_d;
`ifdef ALARM_SNOOZE_LIMIT_EN
    logic [1:0]  snz_num_q, snz_num_d;
`endif

    logic [2:0]  match_s;
    logic [2:0]  clr_s;
    logic        stop_edge_s;
    logic        snz_edge_s;
    logic [7:0]  ring_cnt_inc_s;
    logic [9:0]  snz_cnt_inc_s;
    logic [1:0]  first_s;

    // Lowest set index of the pending vector (fixed priority: alarm 1 first).
    function automatic logic [1:0] first_set(input logic [2:0] vec);
        logic [1:0] idx;
        if (vec[0]) begin
            idx = 2'd0;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd2;
        end
        return idx;
    endfunction

    // Match detection, button edges and saturating counter increments.
    always_comb begin
        match_s[0]     = tick_1hz & alarm_en[0] & (alarm_time1 == cur_time);
        match_s[1]     = tick_1hz & alarm_en[1] & (alarm_time2 == cur_time);
        match_s[2]     = tick_1hz & alarm_en[2] & (alarm_time3 == cur_time);
        stop_edge_s    = stop_btn & ~stop_btn_q;
        snz_edge_s     = snooze_btn & ~snz_btn_q;
        ring_cnt_inc_s = (ring_cnt_q == 8'hFF) ? ring_cnt_q : (ring_cnt_q + {7'd0, tick_1hz});
        snz_cnt_inc_s  = (snz_cnt_q == 10'h3FF) ? snz_cnt_q : (snz_cnt_q + {9'd0, tick_1hz});
        first_s        = first_set(pending_q);
    end

    // Next-state logic for the service FSM, counters and pending queue.
    always_comb begin
        state_d    = state_q;
        ring_id_d  = ring_id_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        clr_s      = 3'b000;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snz_num_d  = snz_num_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pending_q != 3'b000) begin
                    state_d    = ST_RING;
                    ring_id_d  = first_s;
                    clr_s      = 3'b001 << first_s;
                    ring_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snz_num_d  = 2'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RING: begin
                // Timeout is judged on the count including this cycle's tick.
                if (stop_edge_s || (ring_cnt_inc_s >= RING_LIMIT)) begin
                    state_d = ST_IDLE;
                end else if (snz_edge_s) begin
`ifdef ALARM_SNOOZE_LIMIT_EN
                    if (snz_num_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        snz_num_d = snz_num_q + 2'd1;
                        state_d   = ST_SNOOZE;
                        snz_cnt_d = 10'd0;
                    end
`else
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = 10'd0;
`endif
                end else begin
                    ring_cnt_d = ring_cnt_inc_s;
                end
            end
            ST_SNOOZE: begin
                if (stop_edge_s) begin
                    state_d = ST_IDLE;
                end else if (snz_cnt_inc_s >= SNZ_LIMIT) begin
                    state_d    = ST_RING;
                    ring_cnt_d = 8'd0;
                end else begin
                    snz_cnt_d = snz_cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A match in the same cycle as selection keeps its bit queued.
        pending_d  = ((pending_q & ~clr_s) | match_s) & alarm_en;
        ring_d     = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
        stop_btn_d = stop_btn;
        snz_btn_d  = snooze_btn;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ring_q     <= 1'b0;
            ring_id_q  <= 2'd0;
            pending_q  <= 3'b000;
            snoozing_q <= 1'b0;
            ring_cnt_q <= 8'd0;
            snz_cnt_q  <= 10'd0;
            stop_btn_q <= 1'b0;
            snz_btn_q  <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_num_q  <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            ring_id_q  <= ring_id_d;
            pending_q  <= pending_d;
            snoozing_q <= snoozing_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            stop_btn_q <= stop_btn_d;
            snz_btn_q  <= snz_btn_d;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_num_q  <= snz_num_d;
`endif
        end
    end

    assign ring     = ring_q;
    assign ring_id  = ring_id_q;
    assign pending  = pending_q;
    assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_ring_scheduler.sv
// Self-checking bench for alarm_ring_scheduler: vector table, corner-case sequences
// and randomized traffic compared against a rule-level reference model.
module tb_alarm_ring_scheduler;

    localparam int RING_S = 4;
    localparam int SNZ_S  = 3;
`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        tick_1hz;
    logic [23:0] cur_time;
    logic [23:0] alarm_time1, alarm_time2, alarm_time3;
    logic [2:0]  alarm_en;
    logic        stop_btn, snooze_btn;
    logic        ring;
    logic [1:0]  ring_id;
    logic [2:0]  pending;
    logic        snoozing;

    int n_chk  = 0;
    int n_fail = 0;

    alarm_ring_scheduler #(.RING_SECONDS(RING_S), .SNOOZE_SECONDS(SNZ_S)) dut (
        .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .cur_time(cur_time),
        .alarm_time1(alarm_time1), .alarm_time2(alarm_time2), .alarm_time3(alarm_time3),
        .alarm_en(alarm_en), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .ring(ring), .ring_id(ring_id), .pending(pending), .snoozing(snoozing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1);
    end

    // Reference model: mode 0 idle, 1 ringing, 2 snoozing.
    int         m_mode, m_rc, m_sc, m_nsnz;
    logic [1:0] m_id;
    bit   [2:0] m_pend;
    bit         m_pstop, m_psnz;

    task automatic model_step();
        bit se, ze;
        bit [2:0] hit;
        int sel, rc_n, sc_n;
        if (!reset_n) begin
            m_mode = 0; m_id = 2'd0; m_pend = 3'b000; m_rc = 0; m_sc = 0;
            m_nsnz = 0; m_pstop = 1'b0; m_psnz = 1'b0;
            return;
        end
        se = stop_btn && !m_pstop;
        ze = snooze_btn && !m_psnz;
        hit[0] = tick_1hz && alarm_en[0] && (alarm_time1 == cur_time);
        hit[1] = tick_1hz && alarm_en[1] && (alarm_time2 == cur_time);
        hit[2] = tick_1hz && alarm_en[2] && (alarm_time3 == cur_time);
        sel = -1;
        if (m_mode == 0) begin
            for (int i = 0; i < 3; i++) if (m_pend[i] && sel < 0) sel = i;
            if (sel >= 0) begin
                m_mode = 1; m_id = 2'(sel); m_rc = 0; m_nsnz = 0;
            end
        end else if (m_mode == 1) begin
            rc_n = (m_rc + int'(tick_1hz) > 255) ? 255 : m_rc + int'(tick_1hz);
            if (se || rc_n >= RING_S) m_mode = 0;
            else if (ze) begin
                if (LIMIT_ON && m_nsnz == 3) m_mode = 0;
                else begin m_nsnz++; m_mode = 2; m_sc = 0; end
            end else m_rc = rc_n;
        end else begin
            sc_n = (m_sc + int'(tick_1hz) > 1023) ? 1023 : m_sc + int'(tick_1hz);
            if (se) m_mode = 0;
            else if (sc_n >= SNZ_S) begin m_mode = 1; m_rc = 0; end
            else m_sc = sc_n;
        end
        for (int i = 0; i < 3; i++)
            m_pend[i] = ((m_pend[i] && i != sel) || hit[i]) && alarm_en[i];
        m_pstop = stop_btn;
        m_psnz  = snooze_btn;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic r, input logic [1:0] id,
                       input logic [2:0] p, input logic s);
        n_chk++;
        if (ring !== r || ring_id !== id || pending !== p || snoozing !== s) begin
            n_fail++;
            $display("FAIL %s: got ring=%b id=%0d pend=%b snz=%b, want ring=%b id=%0d pend=%b snz=%b",
                     nm, ring, ring_id, pending, snoozing, r, id, p, s);
        end
    endtask

    task automatic tick_step(input logic [23:0] t);
        cur_time = t; tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0; cur_time = 24'h000001;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; tick_1hz = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        tick;
        logic [2:0]  en;
        logic [23:0] cur;
        logic        stop;
        logic        snz;
        logic        e_ring;
        logic [1:0]  e_id;
        logic [2:0]  e_pend;
        logic        e_snz;
    } vec_t;

    vec_t        tbl [20];
    logic [23:0] pool [4];

    initial begin
        reset_n = 1'b0; tick_1hz = 1'b0; cur_time = 24'h0; alarm_en = 3'b000;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        alarm_time1 = 24'h083000; alarm_time2 = 24'h100000; alarm_time3 = 24'h120000;
        m_mode = 0; m_rc = 0; m_sc = 0; m_nsnz = 0; m_id = 2'd0; m_pend = 3'b000;
        m_pstop = 1'b0; m_psnz = 1'b0;

        //          rst   tick  en      cur         stop  snz   ring  id    pend    snz
        tbl[0]  = '{1'b0, 1'b0, 3'b000, 24'h000000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b001, 24'h083000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 3'b001, 24'h083000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b001, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'b001, 24'h000000, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 24'h000000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'b001, 24'h000000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'b001, 24'h000000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'b001, 24'h000000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'b001, 24'h000000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'b111, 24'h120000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b100, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'b111, 24'h000000, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'b111, 24'h100000, 1'b0, 1'b0, 1'b1, 2'd2, 3'b010, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'b111, 24'h000000, 1'b1, 1'b0, 1'b0, 2'd2, 3'b010, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'b111, 24'h000000, 1'b1, 1'b0, 1'b1, 2'd1, 3'b000, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 3'b111, 24'h000000, 1'b0, 1'b1, 1'b0, 2'd1, 3'b000, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 3'b111, 24'h000000, 1'b0, 1'b1, 1'b0, 2'd1, 3'b000, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 3'b111, 24'h000000, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 3'b111, 24'h000000, 1'b0, 1'b0, 1'b1, 2'd1, 3'b000, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 3'b111, 24'h000000, 1'b1, 1'b1, 1'b0, 2'd1, 3'b000, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 3'b110, 24'h083000, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b0};

        for (int v = 0; v < 20; v++) begin
            reset_n = tbl[v].rst_n; tick_1hz = tbl[v].tick; alarm_en = tbl[v].en;
            cur_time = tbl[v].cur; stop_btn = tbl[v].stop; snooze_btn = tbl[v].snz;
            step();
            chk($sformatf("vec%0d", v), tbl[v].e_ring, tbl[v].e_id, tbl[v].e_pend, tbl[v].e_snz);
        end

        // Auto-timeout after RING_S ticks with no button activity.
        do_reset();
        alarm_en = 3'b001;
        tick_1hz = 1'b0;
        tick_step(24'h083000);
        step();
        for (int t = 0; t < RING_S - 1; t++) begin
            tick_step(24'h000001);
            step();
        end
        chk("timeout_before", 1'b1, 2'd0, 3'b000, 1'b0);
        tick_step(24'h000001);
        chk("timeout_drop", 1'b0, 2'd0, 3'b000, 1'b0);

        // Two alarms matching the same second are served in index order.
        do_reset();
        alarm_time1 = 24'h120000; alarm_time3 = 24'h120000; alarm_en = 3'b101;
        tick_step(24'h120000);
        chk("dual_queued", 1'b0, 2'd0, 3'b101, 1'b0);
        step();
        chk("dual_first", 1'b1, 2'd0, 3'b100, 1'b0);
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        chk("dual_stop", 1'b0, 2'd0, 3'b100, 1'b0);
        step();
        chk("dual_second", 1'b1, 2'd2, 3'b000, 1'b0);
        stop_btn = 1'b1; step(); stop_btn = 1'b0; step();

        // Reset while snoozing with another alarm waiting.
        do_reset();
        alarm_time1 = 24'h083000; alarm_time3 = 24'h120000; alarm_en = 3'b111;
        tick_step(24'h083000);
        step();
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        tick_step(24'h100000);
        step();
        chk("snz_waiting", 1'b0, 2'd0, 3'b010, 1'b1);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("snz_reset", 1'b0, 2'd0, 3'b000, 1'b0);

        // Repeated snoozes in one service; the fourth one ends it when limited.
        do_reset();
        alarm_en = 3'b001;
        tick_step(24'h083000);
        step();
        for (int n = 0; n < 3; n++) begin
            snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
            for (int t = 0; t < SNZ_S; t++) tick_step(24'h000001);
        end
        chk("snz_rering3", 1'b1, 2'd0, 3'b000, 1'b0);
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        if (LIMIT_ON) chk("snz_fourth", 1'b0, 2'd0, 3'b000, 1'b0);
        else          chk("snz_fourth", 1'b0, 2'd0, 3'b000, 1'b1);
        stop_btn = 1'b1; step(); stop_btn = 1'b0; step();

        // Randomized traffic against the reference model.
        pool[0] = 24'h083000; pool[1] = 24'h100000; pool[2] = 24'h120000; pool[3] = 24'h235959;
        alarm_en = 3'b111;
        for (int c = 0; c < 2000; c++) begin
            if (c % 500 == 0) begin
                alarm_time1 = pool[$urandom_range(0, 2)];
                alarm_time2 = pool[$urandom_range(0, 2)];
                alarm_time3 = pool[$urandom_range(0, 2)];
            end
            reset_n  = ($urandom_range(0, 399) != 0);
            tick_1hz = ($urandom_range(0, 1) == 1);
            cur_time = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 49) == 0) alarm_en = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 99) == 0) alarm_en = 3'b111;
            if ($urandom_range(0, 5) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 4) == 0) snooze_btn = ~snooze_btn;
            step();
            chk($sformatf("rand%0d", c), (m_mode == 1), m_id, m_pend, (m_mode == 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
